// File: rtl/instr_mem_responder_pkg.sv
// instr_mem_responder_pkg: shared types and constants for the
// instruction-memory responder (FSM states, widths, zero instruction).
package instr_mem_responder_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] NOP_INSTR = '0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } imem_state_t;

endpackage

// File: rtl/instr_mem_responder_byte_array.sv
// imem_byte_array: byte-addressed storage, synchronous byte write,
// combinational little-endian word read at a word-aligned index.
//   clk            clock
//   we/waddr/wdata byte write port
//   ridx           word index for the read
//   rdata          {mem[4i+3], mem[4i+2], mem[4i+1], mem[4i]}
module imem_byte_array
  import instr_mem_responder_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int BW = $clog2(DEPTH_BYTES),
  parameter int IW = BW - 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [BW-1:0]     waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic [IW-1:0]     ridx,
  output logic [WORD_W-1:0] rdata
);

  logic [BYTE_W-1:0] mem [DEPTH_BYTES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = {
    mem[{ridx, 2'b11}],
    mem[{ridx, 2'b10}],
    mem[{ridx, 2'b01}],
    mem[{ridx, 2'b00}]
  };

endmodule

// File: rtl/instr_mem_responder.sv
// instr_mem_responder: fixed-latency instruction fetch responder with a
// one-entry last-fetch buffer and a byte-wide load port.
//   CLK, RESET                    clock, async active-high reset
//   READ, ADDRESS                 fetch request and byte address
//   INSTRUCTION, VALID, ADDR_ERR  fetch result, completion pulse, range error
//   BUSY                          fetch outstanding, CPU stalls
//   LOAD_EN/ADDR/DATA, LOAD_ACK   byte load request and commit pulse
module instr_mem_responder
  import instr_mem_responder_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              READ,
  input  logic [31:0]       ADDRESS,
  output logic [WORD_W-1:0] INSTRUCTION,
  output logic              BUSY,
  output logic              VALID,
  output logic              ADDR_ERR,
  input  logic              LOAD_EN,
  input  logic [31:0]       LOAD_ADDR,
  input  logic [BYTE_W-1:0] LOAD_DATA,
  output logic              LOAD_ACK
);

  localparam int BW = $clog2(DEPTH_BYTES);
  localparam int IW = BW - 2;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
  localparam logic [31:0] LIMIT = 32'(DEPTH_BYTES);

  imem_state_t state_q;
  imem_state_t state_d;

  logic [CW-1:0]     cnt_q;
  logic [29:0]       addr_q;
  logic [29:0]       buf_addr_q;
  logic              buf_vld_q;
  logic [WORD_W-1:0] instr_q;
  logic              valid_q;
  logic              err_q;
  logic              ack_q;

  logic              hit;
  logic              accept_miss;
  logic              done;
  logic              fetch_ok;
  logic              load_ok;
  logic [WORD_W-1:0] rd_word;
  logic [1:0]        unused_addr_lsb;

  // byte offset within the word never affects a fetch
  assign unused_addr_lsb = ADDRESS[1:0];

  assign hit = buf_vld_q
            && (ADDRESS[31:2] == buf_addr_q);
  assign accept_miss = (state_q == S_IDLE)
                    && READ && !hit;
  assign done = (state_q == S_WAIT)
             && (cnt_q == '0);
  assign fetch_ok = {addr_q, 2'b00} < LIMIT;
  // a miss accepted in the same cycle takes priority over a load
  assign load_ok = (state_q == S_IDLE)
                && LOAD_EN
                && !accept_miss
                && (LOAD_ADDR < LIMIT);

  imem_byte_array #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .BW          (BW),
    .IW          (IW)
  ) u_mem (
    .clk   (CLK),
    .we    (load_ok),
    .waddr (LOAD_ADDR[BW-1:0]),
    .wdata (LOAD_DATA),
    .ridx  (addr_q[IW-1:0]),
    .rdata (rd_word)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept_miss) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    BUSY = 1'b0;
    unique case (1'b1)
      (state_q == S_WAIT): BUSY = 1'b1;
      accept_miss:         BUSY = 1'b1;
      default:             BUSY = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q      <= '0;
      addr_q     <= '0;
      buf_addr_q <= '0;
      buf_vld_q  <= 1'b0;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ack_q   <= load_ok;
      if (accept_miss) begin
        addr_q <= ADDRESS[31:2];
        cnt_q  <= CNT_INIT;
      end
      if (state_q == S_WAIT) begin
        if (!done) begin
          cnt_q <= cnt_q - 1'b1;
        end else begin
          instr_q    <= fetch_ok ? rd_word : NOP_INSTR;
          valid_q    <= 1'b1;
          err_q      <= !fetch_ok;
          buf_addr_q <= addr_q;
          // an out-of-range word must never be served as a hit
          buf_vld_q  <= fetch_ok;
        end
      end
      // a write into the buffered word would make the buffer stale
      if (load_ok && (LOAD_ADDR[31:2] == buf_addr_q)) begin
        buf_vld_q <= 1'b0;
      end
    end
  end

  assign INSTRUCTION = instr_q;
  assign VALID       = valid_q;
  assign ADDR_ERR    = err_q;
  assign LOAD_ACK    = ack_q;

endmodule
